// File: rtl/key_ctrl.sv
// rtl/key_ctrl.sv - key synchroniser/debouncer with start/stop/clear FSM for the stopwatch chain
// Produces gated 1 s increments and a soft-reset pulse for the first counter stage.
module key_ctrl #(
    parameter int NKEYS      = 8,
    parameter int STABLE_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smpl_strb,
    input  logic             pps,
    input  logic [NKEYS-1:0] keys_raw,
    output logic [NKEYS-1:0] keys_db,
    output logic [NKEYS-1:0] key_rise,
    output logic             run,
    output logic [1:0]       state,
    output logic             incr,
    output logic             sft_rst
);

    localparam int              CW       = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0]   STABLE_V = CW'(STABLE_CNT);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic [NKEYS-1:0] sync1_q;
    logic [NKEYS-1:0] sync_q;
    logic [CW-1:0]    cnt_q [NKEYS];
    logic [CW-1:0]    cnt_d [NKEYS];
    logic [NKEYS-1:0] db_q,   db_d;
    logic [NKEYS-1:0] rise_q, rise_d;
    logic [1:0]       state_q, state_d;
    logic             clr_q;
    logic             sft_rst_q;
    logic             incr_q;

    logic             start_evt;
    logic             clear_evt;

    assign start_evt = rise_q[0];
    assign clear_evt = rise_q[1];

    // A key's counter only advances while its synchronised level disagrees with the
    // accepted level; any agreeing strobe restarts the stability window.
    always_comb begin
        db_d   = db_q;
        rise_d = '0;
        for (int i = 0; i < NKEYS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (smpl_strb) begin
                if (sync_q[i] != db_q[i]) begin
                    if (cnt_q[i] + CNT_ONE == STABLE_V) begin
                        db_d[i]   = sync_q[i];
                        rise_d[i] = sync_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_evt) state_d = RUN;
            RUN:     if (start_evt) state_d = PAUSE;
            PAUSE:   if (start_evt) state_d = RUN;
            default: state_d = IDLE;
        endcase
        // Clear overrides start/stop, including from the unused encoding.
        if (clear_evt) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync_q    <= '0;
            db_q      <= '0;
            rise_q    <= '0;
            state_q   <= IDLE;
            clr_q     <= 1'b0;
            sft_rst_q <= 1'b0;
            incr_q    <= 1'b0;
            for (int i = 0; i < NKEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= keys_raw;
            sync_q    <= sync1_q;
            db_q      <= db_d;
            rise_q    <= rise_d;
            state_q   <= state_d;
            clr_q     <= clear_evt;
            sft_rst_q <= clr_q;
            incr_q    <= pps & (state_q == RUN) & ~clear_evt;
            for (int i = 0; i < NKEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign keys_db  = db_q;
    assign key_rise = rise_q;
    assign state    = state_q;
    assign run      = (state_q == RUN);
    assign incr     = incr_q;
    assign sft_rst  = sft_rst_q;

endmodule

// File: tb/tb_key_ctrl.sv
// tb/tb_key_ctrl.sv - self-checking bench for key_ctrl
module tb_key_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       smpl_strb;
    logic       pps;
    logic [7:0] keys_raw;
    logic [7:0] keys_db;
    logic [7:0] key_rise;
    logic       run;
    logic [1:0] state;
    logic       incr;
    logic       sft_rst;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic incr_exp_q [$];
    logic mon_e;

    always #5 clk = ~clk;

    key_ctrl #(.NKEYS(8), .STABLE_CNT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .smpl_strb (smpl_strb),
        .pps       (pps),
        .keys_raw  (keys_raw),
        .keys_db   (keys_db),
        .key_rise  (key_rise),
        .run       (run),
        .state     (state),
        .incr      (incr),
        .sft_rst   (sft_rst)
    );

    task automatic tick(input logic strb, input logic p);
        smpl_strb = strb;
        pps       = p;
        @(posedge clk);
        #1;
        smpl_strb = 1'b0;
        pps       = 1'b0;
    endtask

    task automatic pps_tick(input logic e);
        incr_exp_q.push_back(e);
        tick(1'b0, 1'b1);
    endtask

    task automatic press_key(input logic [7:0] mask);
        keys_raw = keys_raw | mask;
        tick(0, 0); tick(0, 0);
        repeat (4) tick(1, 0);
        tick(0, 0);
        keys_raw = keys_raw & ~mask;
        tick(0, 0); tick(0, 0);
        repeat (4) tick(1, 0);
        tick(0, 0);
    endtask

    // incr scoreboard: each pps pops one expectation for the following cycle,
    // and the cycle after that must be low again.
    always begin
        @(posedge clk);
        if (pps === 1'b1) begin
            #2;
            tests_run++;
            if (incr_exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL incr_scoreboard: incr=%b with no expected entry", incr);
            end else begin
                mon_e = incr_exp_q.pop_front();
                if (incr !== mon_e) begin
                    tests_failed++;
                    $display("FAIL incr_after_pps: got %b expected %b", incr, mon_e);
                end
            end
            @(posedge clk);
            #2;
            tests_run++;
            if (incr !== 1'b0) begin
                tests_failed++;
                $display("FAIL incr_width: got %b expected 0", incr);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; keys_raw = 8'h00;
        tick(0, 0); tick(0, 0); tick(0, 0);
        tests_run++;
        if ({keys_db, key_rise} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_keys: got db=%h rise=%h expected 00 00", keys_db, key_rise);
        end
        tests_run++;
        if ({state, run, incr, sft_rst} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got state=%0d run=%b incr=%b sft_rst=%b expected all 0",
                     state, run, incr, sft_rst);
        end
        keys_raw = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            tick(1, 0);
            tests_run++;
            if (keys_db !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_hold_db: got %h expected 00", keys_db);
            end
        end
        keys_raw = 8'h00;
        rst      = 1'b0;
        tick(0, 0); tick(0, 0); tick(0, 0);
    endtask

    task automatic test_press_start();
        keys_raw[0] = 1'b1;
        tick(0, 0); tick(0, 0);
        for (int k = 1; k <= 4; k++) begin
            repeat (9) tick(0, 0);
            tick(1, 0);
            if (k < 4) begin
                tests_run++;
                if (keys_db !== 8'h00) begin
                    tests_failed++;
                    $display("FAIL press_early_db: strobe %0d got %h expected 00", k, keys_db);
                end
            end else begin
                tests_run++;
                if ({keys_db, key_rise, state} !== {8'h01, 8'h01, 2'd0}) begin
                    tests_failed++;
                    $display("FAIL press_accept: got db=%h rise=%h state=%0d expected 01 01 0",
                             keys_db, key_rise, state);
                end
            end
        end
        tick(0, 0);
        tests_run++;
        if ({key_rise, state, run} !== {8'h00, 2'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL press_run: got rise=%h state=%0d run=%b expected 00 1 1", key_rise, state, run);
        end
        keys_raw[0] = 1'b0;
        tick(0, 0); tick(0, 0);
        for (int k = 1; k <= 4; k++) begin
            tick(1, 0);
            tests_run++;
            if ({keys_db, key_rise} !== {(k < 4) ? 8'h01 : 8'h00, 8'h00}) begin
                tests_failed++;
                $display("FAIL release_b2b: strobe %0d got db=%h rise=%h", k, keys_db, key_rise);
            end
        end
        tick(0, 0);
        tests_run++;
        if (state !== 2'd1) begin
            tests_failed++;
            $display("FAIL release_state: got %0d expected 1", state);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat  = 8'b0011_0111;
        logic       seen = 1'b0;
        for (int p = 0; p < 8; p++) begin
            keys_raw[0] = pat[p];
            for (int c = 0; c < 10; c++) begin
                tick(c == 9, 0);
                seen = seen | (keys_db != 8'h00) | (key_rise != 8'h00);
            end
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_reject: got activity=%b expected 0", seen);
        end
        tests_run++;
        if (state !== 2'd1) begin
            tests_failed++;
            $display("FAIL bounce_state: got %0d expected 1", state);
        end
    endtask

    task automatic test_pps_gating();
        for (int k = 0; k < 2; k++) begin
            repeat (99) tick(0, 0);
            pps_tick(1'b1);
        end
        press_key(8'h01);
        tests_run++;
        if ({state, run} !== {2'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL pause_state: got state=%0d run=%b expected 2 0", state, run);
        end
        for (int k = 0; k < 2; k++) begin
            repeat (99) tick(0, 0);
            pps_tick(1'b0);
        end
        press_key(8'h01);
        tests_run++;
        if ({state, run} !== {2'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL resume_state: got state=%0d run=%b expected 1 1", state, run);
        end
        repeat (99) tick(0, 0);
        pps_tick(1'b1);
        repeat (3) tick(0, 0);
    endtask

    task automatic test_clear_collision();
        keys_raw = keys_raw | 8'h03;
        tick(0, 0); tick(0, 0);
        repeat (4) tick(1, 0);
        tests_run++;
        if ({key_rise, state} !== {8'h03, 2'd1}) begin
            tests_failed++;
            $display("FAIL collide_rise: got rise=%h state=%0d expected 03 1", key_rise, state);
        end
        pps_tick(1'b0);
        tests_run++;
        if ({state, sft_rst, key_rise} !== {2'd0, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL collide_idle: got state=%0d sft_rst=%b rise=%h expected 0 0 00",
                     state, sft_rst, key_rise);
        end
        tick(0, 0);
        tests_run++;
        if ({sft_rst, state} !== {1'b1, 2'd0}) begin
            tests_failed++;
            $display("FAIL collide_sft_rst: got sft_rst=%b state=%0d expected 1 0", sft_rst, state);
        end
        tick(0, 0);
        tests_run++;
        if (sft_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL collide_sft_width: got %b expected 0", sft_rst);
        end
        keys_raw = keys_raw & ~8'h03;
        tick(0, 0); tick(0, 0);
        repeat (4) tick(1, 0);
        tick(0, 0); tick(0, 0);
    endtask

    task automatic test_clear_idle();
        keys_raw = keys_raw | 8'h02;
        tick(0, 0); tick(0, 0);
        repeat (4) tick(1, 0);
        tick(0, 0);
        tests_run++;
        if (sft_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_clear_early: got %b expected 0", sft_rst);
        end
        tick(0, 0);
        tests_run++;
        if ({sft_rst, state} !== {1'b1, 2'd0}) begin
            tests_failed++;
            $display("FAIL idle_clear_pulse: got sft_rst=%b state=%0d expected 1 0", sft_rst, state);
        end
        keys_raw = keys_raw & ~8'h02;
        tick(0, 0); tick(0, 0);
        repeat (4) tick(1, 0);
        tick(0, 0); tick(0, 0);
    endtask

    task automatic test_illegal_state();
        force dut.state_q = 2'd3;
        #1;
        tests_run++;
        if ({state, run} !== {2'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL illegal_forced: got state=%0d run=%b expected 3 0", state, run);
        end
        release dut.state_q;
        tick(0, 0);
        tests_run++;
        if ({state, sft_rst} !== {2'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL illegal_recover: got state=%0d sft_rst=%b expected 0 0", state, sft_rst);
        end
        tick(0, 0);
        tests_run++;
        if (sft_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL illegal_no_sft: got %b expected 0", sft_rst);
        end
    endtask

    task automatic test_reset_mid();
        keys_raw[2] = 1'b1;
        tick(0, 0); tick(0, 0);
        tick(1, 0); tick(1, 0);
        rst = 1'b1;
        tick(1, 0);
        rst = 1'b0;
        tests_run++;
        if (keys_db !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset_db: got %h expected 00", keys_db);
        end
        tick(0, 0); tick(0, 0);
        repeat (3) tick(1, 0);
        tests_run++;
        if (keys_db !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset_window: got %h expected 00", keys_db);
        end
        tick(1, 0);
        tests_run++;
        if ({keys_db, key_rise} !== {8'h04, 8'h04}) begin
            tests_failed++;
            $display("FAIL mid_reset_accept: got db=%h rise=%h expected 04 04", keys_db, key_rise);
        end
        tick(0, 0);
        tests_run++;
        if ({state, key_rise} !== {2'd0, 8'h00}) begin
            tests_failed++;
            $display("FAIL key2_no_fsm: got state=%0d rise=%h expected 0 00", state, key_rise);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        smpl_strb = 1'b0;
        pps       = 1'b0;
        keys_raw  = 8'h00;
        test_reset();
        test_press_start();
        test_bounce();
        test_pps_gating();
        test_clear_collision();
        test_clear_idle();
        test_illegal_state();
        test_reset_mid();
        repeat (3) tick(0, 0);
        tests_run++;
        if (incr_exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL incr_queue_drain: got %0d pending expected 0", incr_exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/key_ctrl.md
# key_ctrl

Upstream control stage for the stopwatch counter chain. It synchronises and debounces the raw switch/key inputs using the sample strobe from the pulse generator. A start/stop/clear state machine then produces the gated 1 s increment pulse and the soft-reset pulse that drive the first counter. It also exports clean debounced key levels for the LEDs and other consumers.

## Interface

Parameters:
- NKEYS, 8, number of key inputs (min 2; key 0 = start/stop, key 1 = clear)
- STABLE_CNT, 4, consecutive sample strobes a new level must persist before it is accepted (≥1)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- smpl_strb  in  1  one-cycle debounce sample strobe from the pulse generator
- pps  in  1  one-cycle 1 s pulse from the pulse generator
- keys_raw  in  NKEYS  asynchronous switch/key levels, active-high
- keys_db  out  NKEYS  debounced key levels
- key_rise  out  NKEYS  one-cycle pulse per debounced 0→1 transition
- run  out  1  high in RUN state
- state  out  2  FSM state: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2
- incr  out  1  gated increment pulse to the counter chain
- sft_rst  out  1  one-cycle clear pulse to the counter chain

## Operation

- Synchroniser: two flops per bit on keys_raw. The output of the second flop is `sync`. Both flops reset to 0.
- Debounce, per key, with counter width clog2(STABLE_CNT+1):
  - Logic acts only in cycles where smpl_strb=1.
  - If sync[i] ≠ keys_db[i], the counter increments. When the incremented value equals STABLE_CNT, keys_db[i] takes sync[i] and the counter clears.
  - If sync[i] = keys_db[i] on a strobe, the counter clears.
  - Cycles without a strobe leave the counter and keys_db unchanged.
- key_rise[i] is registered and asserts on the same edge at which keys_db[i] goes 0→1. It is high for exactly one clk. A 1→0 transition produces no pulse.
- FSM, driven by key_rise[0] (start/stop) and key_rise[1] (clear):
  - IDLE on key_rise[0] → RUN.
  - RUN on key_rise[0] → PAUSE.
  - PAUSE on key_rise[0] → RUN.
  - Any state on key_rise[1] → IDLE, with sft_rst=1 on the next cycle.
  - When key_rise[0] and key_rise[1] occur in the same cycle, clear wins: the FSM goes to IDLE and asserts sft_rst.
  - Clear while already in IDLE still produces the sft_rst pulse.
  - Unused state encoding 2'd3 → IDLE on the next edge, with no sft_rst.
- run = (state == RUN), decoded from the state register.
- incr is registered: incr ← pps & run & ~clear_event, where clear_event = key_rise[1]. Any pps that coincides with a clear is suppressed.
- Keys 2..NKEYS-1 are debounced only. They have no effect on the FSM.

## Timing

- Reset values: keys_db=0, key_rise=0, state=IDLE, run=0, incr=0, sft_rst=0. Synchroniser and debounce counters also reset to 0.
- rst has priority over every other input in the same cycle. Reset mid-debounce discards the partial count.
- Latency from a keys_raw change to keys_db:
  - 2 clk for synchronisation.
  - Then the STABLE_CNT-th qualifying strobe.
  - keys_db updates at the edge of that strobe cycle.
- key_rise to FSM state change: 1 clk. state/run update at the edge following the key_rise cycle.
- key_rise[1] to sft_rst: sft_rst is high in the cycle after state becomes IDLE, i.e. 2 clk after key_rise[1]. It lasts exactly 1 clk.
- pps to incr: 1 clk. incr is never high for more than 1 clk per pps.
- A glitch lasting fewer than STABLE_CNT consecutive strobes is fully rejected, and keys_db does not change.
- Strobes that arrive back-to-back (smpl_strb held high) are each counted. The block must then debounce in STABLE_CNT clk.

## Test plan

- Reset with all inputs at 0 → all outputs 0, state=0. Drive keys_raw=8'hFF with rst held high for 10 strobes → keys_db stays 8'h00.
- STABLE_CNT=4, strobe every 10 clk. Raise keys_raw[0] and hold → keys_db[0]=1 at the 4th strobe after sync. key_rise[0] is high 1 clk. state goes 0→1 one clk later.
- Bounce keys_raw[0] high for 3 strobes, low for 1, high for 2, then low → keys_db[0] never rises, key_rise=0, state unchanged.
- From RUN, pps every 100 clk → incr follows each pps by 1 clk. Press key 0 → PAUSE, and subsequent pps give incr=0. Press key 0 again → RUN, and incr resumes.
- In RUN, debounced rises of key 0 and key 1 arrive in the same cycle, together with pps → state=IDLE, sft_rst=1 for exactly 1 clk, incr stays 0.
- Force the state register to 2'd3 → state=IDLE next clk, sft_rst=0. Assert rst during the 3rd qualifying strobe of a key-2 press → keys_db[2] stays 0, and a new full 4-strobe window is required afterwards.
